picorv32_wb_master: RTL and testbench

//  Bridges the picorv32 native memory port to the SoC Wishbone pipelined bus; sits directly upstream of wb_interconnect.

---
 rtl/picorv32_wb_master_pkg.sv | 11 +
 rtl/picorv32_wb_master_if.sv | 37 +++
 rtl/picorv32_wb_master_timeout.sv | 24 ++
 rtl/picorv32_wb_master.sv | 103 ++++++++++
 tb/tb_picorv32_wb_master.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/picorv32_wb_master_pkg.sv
// picorv32_wb_master_pkg: shared FSM encodings, defaults and the byte-select helper for the Wishbone bridge
package picorv32_wb_master_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int TO_W = 16;
  function automatic logic [3:0] wb_sel(input logic [3:0] wstrb);
    return |wstrb ? wstrb : 4'hF;
  endfunction
endpackage

// File: rtl/picorv32_wb_master_if.sv
// picorv32_wb_master_if: picorv32 native memory port plus Wishbone pipelined master signals.
//   master modport: the bridge (drives o_*, samples i_*); slave modport: core + interconnect side.
interface picorv32_wb_master_if;
  logic        i_mem_valid;
  logic        i_mem_instr;
  logic        o_mem_ready;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [3:0]  i_mem_wstrb;
  logic [31:0] o_mem_rdata;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic [31:0] i_wb_data;
  logic        o_bus_err;
  logic        o_bus_timeout;
  logic [31:0] o_bus_err_addr;
  logic        o_bus_err_instr;
  modport master (
    input  i_mem_valid, i_mem_instr, i_mem_addr, i_mem_wdata, i_mem_wstrb,
    input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
    output o_mem_ready, o_mem_rdata, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output o_bus_err, o_bus_timeout, o_bus_err_addr, o_bus_err_instr
  );
  modport slave (
    output i_mem_valid, i_mem_instr, i_mem_addr, i_mem_wdata, i_mem_wstrb,
    output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
    input  o_mem_ready, o_mem_rdata, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  o_bus_err, o_bus_timeout, o_bus_err_addr, o_bus_err_instr
  );
endinterface

// File: rtl/picorv32_wb_master_timeout.sv
// wb_bus_timeout: saturating cycle counter flagging a stuck Wishbone access.
//   i_clear restarts at 0, i_enable counts one cycle, o_expired is high in the cycle
//   that completes TIMEOUT_CYCLES counted cycles while enabled.
module wb_bus_timeout
  import picorv32_wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  logic [TO_W-1:0] count_q, count_d;
  always_comb begin
    count_d = i_clear ? '0 : (i_enable && count_q != '1) ? count_q + TO_W'(1) : count_q;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) count_q <= '0;
    else count_q <= count_d;
  end
  assign o_expired = i_enable && !i_clear && (32'(count_q) >= TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/picorv32_wb_master.sv
// picorv32_wb_master: bridges picorv32 memory requests to single-beat Wishbone pipelined cycles.
//   i_clk/i_reset: clock and async active-high reset; bus (master modport): core request/response,
//   Wishbone cyc/stb/we/addr/data/sel with stall/ack/err, and error/timeout status.
//   Slave errors and timeouts complete the access with ERR_RDATA and pulse o_bus_err.
module picorv32_wb_master
  import picorv32_wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  picorv32_wb_master_if.master       bus
);
  logic [1:0]  state_q, state_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [3:0]  sel_q, sel_d;
  logic        instr_q, instr_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d, timeout_q, timeout_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_instr_q, err_instr_d;
  logic        launch, busy, expired, err_hit, to_hit, done, fail, finish;
  wb_bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (launch),
    .i_enable  (busy),
    .o_expired (expired)
  );
  always_comb begin
    // ready_q guards against relaunching on the cycle the core still holds valid after completion
    launch      = state_q == ST_IDLE && bus.i_mem_valid && !ready_q;
    busy        = state_q == ST_REQ || state_q == ST_WAIT;
    err_hit     = busy && bus.i_wb_err;
    done        = busy && bus.i_wb_ack && !bus.i_wb_err;
    to_hit      = busy && !bus.i_wb_err && !bus.i_wb_ack && expired;
    fail        = err_hit || to_hit;
    finish      = fail || done;
    state_d     = launch ? ST_REQ : finish ? ST_IDLE :
                  (state_q == ST_REQ && !bus.i_wb_stall) ? ST_WAIT : busy ? state_q : ST_IDLE;
    cyc_d       = launch || (busy && !finish);
    stb_d       = launch || (state_q == ST_REQ && bus.i_wb_stall && !finish);
    we_d        = launch ? |bus.i_mem_wstrb : we_q;
    addr_d      = launch ? bus.i_mem_addr : addr_q;
    data_d      = launch ? bus.i_mem_wdata : data_q;
    sel_d       = launch ? wb_sel(bus.i_mem_wstrb) : sel_q;
    instr_d     = launch ? bus.i_mem_instr : instr_q;
    ready_d     = finish;
    rdata_d     = fail ? ERR_RDATA : (done && !we_q) ? bus.i_wb_data : rdata_q;
    err_d       = fail;
    timeout_d   = to_hit;
    err_addr_d  = fail ? addr_q : err_addr_q;
    err_instr_d = fail ? instr_q : err_instr_q;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      instr_q     <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      err_addr_q  <= '0;
      err_instr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      instr_q     <= instr_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      err_addr_q  <= err_addr_d;
      err_instr_q <= err_instr_d;
    end
  end
  assign bus.o_mem_ready     = ready_q;
  assign bus.o_mem_rdata     = rdata_q;
  assign bus.o_wb_cyc        = cyc_q;
  assign bus.o_wb_stb        = stb_q;
  assign bus.o_wb_we         = we_q;
  assign bus.o_wb_addr       = addr_q;
  assign bus.o_wb_data       = data_q;
  assign bus.o_wb_sel        = sel_q;
  assign bus.o_bus_err       = err_q;
  assign bus.o_bus_timeout   = timeout_q;
  assign bus.o_bus_err_addr  = err_addr_q;
  assign bus.o_bus_err_instr = err_instr_q;
endmodule

// File: tb/tb_picorv32_wb_master.sv
// tb_picorv32_wb_master: directed checks of the picorv32-to-Wishbone bridge
module tb_picorv32_wb_master;
  logic i_clk = 1'b0;
  logic i_reset;
  int   errors = 0;
  int   checks = 0;
  picorv32_wb_master_if bus();
  picorv32_wb_master #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );
  always #5 i_clk = ~i_clk;
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    i_reset = 1'b1;
    bus.i_mem_valid = 0; bus.i_mem_instr = 0; bus.i_mem_addr = 0; bus.i_mem_wdata = 0; bus.i_mem_wstrb = 0;
    bus.i_wb_stall = 0; bus.i_wb_ack = 0; bus.i_wb_err = 0; bus.i_wb_data = 0;
    #1;
    chk("rst_cyc", 32'(bus.o_wb_cyc), 0);
    chk("rst_stb", 32'(bus.o_wb_stb), 0);
    chk("rst_ready", 32'(bus.o_mem_ready), 0);
    chk("rst_rdata", bus.o_mem_rdata, 0);
    chk("rst_err", 32'(bus.o_bus_err), 0);
    chk("rst_err_addr", bus.o_bus_err_addr, 0);
    tick(); tick();
    i_reset = 1'b0;
    tick();
    // plain read, ack one cycle after stb accepted
    bus.i_mem_valid = 1; bus.i_mem_addr = 32'h8000_0000; bus.i_mem_wstrb = 0;
    tick();
    chk("rd_stb", 32'(bus.o_wb_stb), 1);
    chk("rd_cyc", 32'(bus.o_wb_cyc), 1);
    chk("rd_we", 32'(bus.o_wb_we), 0);
    chk("rd_sel", 32'(bus.o_wb_sel), 32'hF);
    chk("rd_addr", bus.o_wb_addr, 32'h8000_0000);
    tick();
    chk("rd_wait_stb", 32'(bus.o_wb_stb), 0);
    chk("rd_wait_cyc", 32'(bus.o_wb_cyc), 1);
    chk("rd_wait_ready", 32'(bus.o_mem_ready), 0);
    bus.i_wb_ack = 1; bus.i_wb_data = 32'h0000_002A;
    tick();
    chk("rd_ready", 32'(bus.o_mem_ready), 1);
    chk("rd_rdata", bus.o_mem_rdata, 32'h0000_002A);
    chk("rd_cyc_drop", 32'(bus.o_wb_cyc), 0);
    bus.i_wb_ack = 0;
    tick();
    chk("rd_ready_once", 32'(bus.o_mem_ready), 0);
    chk("rd_no_relaunch", 32'(bus.o_wb_cyc), 0);
    bus.i_mem_valid = 0;
    // write with stall held for three cycles
    bus.i_mem_valid = 1; bus.i_mem_addr = 32'h8000_0010; bus.i_mem_wdata = 32'h1234_5678;
    bus.i_mem_wstrb = 4'b0011; bus.i_wb_stall = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("wr_stb_held", 32'(bus.o_wb_stb), 1);
      chk("wr_addr", bus.o_wb_addr, 32'h8000_0010);
      chk("wr_data", bus.o_wb_data, 32'h1234_5678);
      chk("wr_sel", 32'(bus.o_wb_sel), 32'h3);
      chk("wr_we", 32'(bus.o_wb_we), 1);
      if (i == 4) bus.i_wb_stall = 0;
    end
    tick();
    chk("wr_stb_drop", 32'(bus.o_wb_stb), 0);
    chk("wr_cyc_wait", 32'(bus.o_wb_cyc), 1);
    bus.i_wb_ack = 1;
    tick();
    chk("wr_ready", 32'(bus.o_mem_ready), 1);
    chk("wr_rdata_kept", bus.o_mem_rdata, 32'h0000_002A);
    bus.i_wb_ack = 0;
    tick();
    chk("wr_ready_once", 32'(bus.o_mem_ready), 0);
    bus.i_mem_valid = 0; bus.i_mem_wstrb = 0;
    // slave error during WAIT
    bus.i_mem_valid = 1; bus.i_mem_addr = 32'h9000_0000; bus.i_mem_instr = 1;
    tick(); tick();
    bus.i_wb_err = 1;
    tick();
    chk("err_ready", 32'(bus.o_mem_ready), 1);
    chk("err_rdata", bus.o_mem_rdata, 32'hDEAD_BEEF);
    chk("err_pulse", 32'(bus.o_bus_err), 1);
    chk("err_timeout", 32'(bus.o_bus_timeout), 0);
    chk("err_addr", bus.o_bus_err_addr, 32'h9000_0000);
    chk("err_instr", 32'(bus.o_bus_err_instr), 1);
    chk("err_cyc", 32'(bus.o_wb_cyc), 0);
    bus.i_wb_err = 0;
    tick();
    chk("err_pulse_end", 32'(bus.o_bus_err), 0);
    chk("err_addr_held", bus.o_bus_err_addr, 32'h9000_0000);
    bus.i_mem_valid = 0; bus.i_mem_instr = 0;
    // timeout: no response for 8 cycles
    bus.i_mem_valid = 1; bus.i_mem_addr = 32'hA000_0000;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("to_cyc_held", 32'(bus.o_wb_cyc), 1);
      chk("to_no_err", 32'(bus.o_bus_err), 0);
    end
    tick();
    chk("to_cyc_drop", 32'(bus.o_wb_cyc), 0);
    chk("to_err", 32'(bus.o_bus_err), 1);
    chk("to_timeout", 32'(bus.o_bus_timeout), 1);
    chk("to_ready", 32'(bus.o_mem_ready), 1);
    chk("to_rdata", bus.o_mem_rdata, 32'hDEAD_BEEF);
    chk("to_err_addr", bus.o_bus_err_addr, 32'hA000_0000);
    chk("to_err_instr", 32'(bus.o_bus_err_instr), 0);
    tick();
    chk("to_timeout_end", 32'(bus.o_bus_timeout), 0);
    bus.i_mem_valid = 0;
    // ack and err together: error wins
    bus.i_mem_valid = 1; bus.i_mem_addr = 32'hB000_0000;
    tick(); tick();
    bus.i_wb_ack = 1; bus.i_wb_err = 1; bus.i_wb_data = 32'h0000_0055;
    tick();
    chk("ae_ready", 32'(bus.o_mem_ready), 1);
    chk("ae_rdata", bus.o_mem_rdata, 32'hDEAD_BEEF);
    chk("ae_err", 32'(bus.o_bus_err), 1);
    chk("ae_err_addr", bus.o_bus_err_addr, 32'hB000_0000);
    bus.i_wb_ack = 0; bus.i_wb_err = 0;
    tick();
    bus.i_mem_valid = 0;
    // ack in the same cycle stb is accepted
    bus.i_mem_valid = 1; bus.i_mem_addr = 32'h0000_0100;
    tick();
    bus.i_wb_ack = 1; bus.i_wb_data = 32'h0000_0077;
    tick();
    chk("fast_ready", 32'(bus.o_mem_ready), 1);
    chk("fast_rdata", bus.o_mem_rdata, 32'h0000_0077);
    chk("fast_cyc", 32'(bus.o_wb_cyc), 0);
    chk("fast_no_err", 32'(bus.o_bus_err), 0);
    bus.i_wb_ack = 0;
    tick();
    bus.i_mem_valid = 0;
    // responses while idle are ignored
    bus.i_wb_ack = 1; bus.i_wb_err = 1; bus.i_wb_stall = 1;
    tick(); tick();
    chk("idle_cyc", 32'(bus.o_wb_cyc), 0);
    chk("idle_ready", 32'(bus.o_mem_ready), 0);
    chk("idle_err", 32'(bus.o_bus_err), 0);
    bus.i_wb_ack = 0; bus.i_wb_err = 0; bus.i_wb_stall = 0;
    // back-to-back reads: no duplicate cycle on the valid-drop edge
    bus.i_mem_valid = 1; bus.i_mem_addr = 32'h0000_0200;
    tick(); tick();
    bus.i_wb_ack = 1; bus.i_wb_data = 32'h0000_0011;
    tick();
    chk("b2b_ready1", 32'(bus.o_mem_ready), 1);
    chk("b2b_rdata1", bus.o_mem_rdata, 32'h0000_0011);
    bus.i_wb_ack = 0;
    tick();
    chk("b2b_no_dup", 32'(bus.o_wb_cyc), 0);
    bus.i_mem_addr = 32'h0000_0204;
    tick();
    chk("b2b_stb2", 32'(bus.o_wb_stb), 1);
    chk("b2b_addr2", bus.o_wb_addr, 32'h0000_0204);
    tick();
    bus.i_wb_ack = 1; bus.i_wb_data = 32'h0000_0022;
    tick();
    chk("b2b_ready2", 32'(bus.o_mem_ready), 1);
    chk("b2b_rdata2", bus.o_mem_rdata, 32'h0000_0022);
    bus.i_wb_ack = 0;
    tick();
    bus.i_mem_valid = 0;
    // reset pulsed during WAIT
    bus.i_mem_valid = 1; bus.i_mem_addr = 32'hC000_0000;
    tick(); tick();
    chk("rw_cyc_before", 32'(bus.o_wb_cyc), 1);
    i_reset = 1;
    #1;
    chk("rw_cyc", 32'(bus.o_wb_cyc), 0);
    chk("rw_stb", 32'(bus.o_wb_stb), 0);
    chk("rw_ready", 32'(bus.o_mem_ready), 0);
    chk("rw_rdata", bus.o_mem_rdata, 0);
    chk("rw_err_addr", bus.o_bus_err_addr, 0);
    bus.i_mem_valid = 0;
    tick(); tick();
    chk("rw_no_ready", 32'(bus.o_mem_ready), 0);
    i_reset = 0;
    tick();
    bus.i_mem_valid = 1; bus.i_mem_addr = 32'hD000_0000;
    tick();
    chk("post_rst_stb", 32'(bus.o_wb_stb), 1);
    chk("post_rst_addr", bus.o_wb_addr, 32'hD000_0000);
    tick();
    bus.i_wb_ack = 1; bus.i_wb_data = 32'h0000_0099;
    tick();
    chk("post_rst_ready", 32'(bus.o_mem_ready), 1);
    chk("post_rst_rdata", bus.o_mem_rdata, 32'h0000_0099);
    bus.i_wb_ack = 0;
    tick();
    bus.i_mem_valid = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
